// File: rtl/button_event_scheduler_pkg.sv
// Shared definitions for the button event scheduler: hold-FSM state encoding,
// event code width and the timing defaults selected by Simulate.
package button_event_scheduler_pkg;

  localparam int NumBtn = 4;
  localparam int CodeW  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } hold_state_e;

  function automatic int tick_div_default(input bit sim);
    return sim ? 4 : 50000;
  endfunction

  function automatic int hold_delay_default(input bit sim);
    return sim ? 3 : 500;
  endfunction

  function automatic int repeat_period_default(input bit sim);
    return sim ? 2 : 100;
  endfunction

endpackage

// File: rtl/button_event_scheduler_hold_fsm.sv
// Per-button press / auto-repeat sequencer; emits a registered 1-cycle event
// pulse with a flag telling a first press from an auto-repeat.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | button released or disabled; waiting for a fresh rising edge
//   ST_HELD   | press reported; counting ticks down to the first repeat
//   ST_REPEAT | auto-repeating; counting ticks down to the next repeat
module button_hold_fsm
  import button_event_scheduler_pkg::*;
#(
  parameter int HoldDelay    = 500,
  parameter int RepeatPeriod = 100,
  parameter int CntW         = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic level,
  input  logic rise,
  input  logic tick,
  input  logic enable,
  output logic event_pulse,
  output logic event_repeat
);

  localparam logic [CntW-1:0] HoldLoad   = CntW'(HoldDelay - 1);
  localparam logic [CntW-1:0] RepeatLoad = CntW'(RepeatPeriod - 1);

  hold_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fire, fire_rep;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      event_pulse  <= 1'b0;
      event_repeat <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      event_pulse  <= fire;
      event_repeat <= fire_rep;
    end
  end

  // A released button or a global disable overrides every other transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!level || !enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d = ST_HELD;
            cnt_d   = HoldLoad;
          end
        end
        ST_HELD, ST_REPEAT: begin
          if (tick) begin
            if (cnt_q == '0) begin
              state_d = ST_REPEAT;
              cnt_d   = RepeatLoad;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    fire     = 1'b0;
    fire_rep = 1'b0;
    if (level && enable) begin
      case (state_q)
        ST_IDLE: fire = rise;
        ST_HELD, ST_REPEAT: begin
          fire     = tick && (cnt_q == '0);
          fire_rep = 1'b1;
        end
        default: fire = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/button_event_scheduler.sv
// Converts debounced button levels into press / auto-repeat events and hands
// them one at a time, round-robin, over a valid/ready interface.
module button_event_scheduler
  import button_event_scheduler_pkg::*;
#(
  parameter bit Simulate     = 1'b0,
  parameter int TickDiv      = tick_div_default(Simulate),
  parameter int HoldDelay    = hold_delay_default(Simulate),
  parameter int RepeatPeriod = repeat_period_default(Simulate),
  parameter int CntW         = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [NumBtn-1:0] iPushBtn,
  input  logic              iEnable,
  input  logic              iEventReady,
  output logic              oEventValid,
  output logic [CodeW-1:0]  oEventCode,
  output logic              oEventRepeat,
  output logic [NumBtn-1:0] oPending,
  output logic              oOverrun
);

  logic [CntW-1:0]   tick_cnt;
  logic              tick;
  logic [NumBtn-1:0] prev_btn, rise;
  logic [NumBtn-1:0] ev, ev_rep;
  logic [NumBtn-1:0] pending, pending_d, rep, rep_d;
  logic [CodeW-1:0]  last, grant_idx, cand;
  logic              grant_found, load, overrun_hit;

  assign tick = (tick_cnt == CntW'(TickDiv - 1));

  always_ff @(posedge Clock) begin
    if (!Reset)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // Loaded during reset too, so a button held through reset is not a press.
  always_ff @(posedge Clock) prev_btn <= iPushBtn;

  assign rise = iPushBtn & ~prev_btn;

  for (genvar k = 0; k < NumBtn; k++) begin : g_btn
    button_hold_fsm #(
      .HoldDelay   (HoldDelay),
      .RepeatPeriod(RepeatPeriod),
      .CntW        (CntW)
    ) u_hold (
      .Clock       (Clock),
      .Reset       (Reset),
      .level       (iPushBtn[k]),
      .rise        (rise[k]),
      .tick        (tick),
      .enable      (iEnable),
      .event_pulse (ev[k]),
      .event_repeat(ev_rep[k])
    );
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last;
    cand        = '0;
    for (int i = 1; i <= NumBtn; i++) begin
      cand = last + CodeW'(i);
      if (!grant_found && pending[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign load = ~oEventValid | iEventReady;

  // A new event on a button being granted this cycle simply re-arms it.
  always_comb begin
    pending_d   = pending;
    rep_d       = rep;
    overrun_hit = 1'b0;
    if (load && grant_found) pending_d[grant_idx] = 1'b0;
    for (int k = 0; k < NumBtn; k++) begin
      if (ev[k]) begin
        pending_d[k] = 1'b1;
        rep_d[k]     = ev_rep[k];
        if (pending[k] && !(load && grant_found && grant_idx == CodeW'(k)))
          overrun_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      pending      <= '0;
      rep          <= '0;
      oOverrun     <= 1'b0;
      oEventValid  <= 1'b0;
      oEventCode   <= '0;
      oEventRepeat <= 1'b0;
      last         <= CodeW'(NumBtn - 1);
    end else begin
      pending <= pending_d;
      rep     <= rep_d;
      if (overrun_hit) oOverrun <= 1'b1;
      if (load) begin
        oEventValid <= grant_found;
        if (grant_found) begin
          oEventCode   <= grant_idx;
          oEventRepeat <= rep[grant_idx];
          last         <= grant_idx;
        end
      end
    end
  end

  assign oPending = pending;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Randomized scoreboard bench for button_event_scheduler with Simulate timing.
module tb_button_event_scheduler;

  localparam int TD = 4;
  localparam int HD = 3;
  localparam int RP = 2;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [3:0] iPushBtn;
  logic       iEnable;
  logic       iEventReady;
  logic       oEventValid;
  logic [1:0] oEventCode;
  logic       oEventRepeat;
  logic [3:0] oPending;
  logic       oOverrun;

  int checks = 0;
  int errors = 0;

  button_event_scheduler #(.Simulate(1'b1)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .iPushBtn    (iPushBtn),
    .iEnable     (iEnable),
    .iEventReady (iEventReady),
    .oEventValid (oEventValid),
    .oEventCode  (oEventCode),
    .oEventRepeat(oEventRepeat),
    .oPending    (oPending),
    .oOverrun    (oOverrun)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: evaluated at each negedge for the coming rising edge.
  typedef struct packed {logic [1:0] code; logic rep;} ev_t;
  ev_t exp_q[$];

  int         m_cyc = 0;
  int         m_ticks[4];
  bit         m_active[4];
  logic [3:0] m_prev = '0, m_pend = '0, m_rep = '0, m_ev = '0, m_evrep = '0;
  logic       m_valid = 1'b0, m_rept = 1'b0, m_over = 1'b0;
  logic [1:0] m_code = '0;
  int         m_last = 3;
  bit         m_init = 1'b0;

  bit         snap_ok = 1'b0;
  logic       snap_valid, snap_over;
  logic [3:0] snap_pend;

  always @(negedge Clock) begin
    bit         tick, load, found;
    int         g;
    logic [3:0] new_ev, new_rep;
    snap_ok    = m_init;
    snap_valid = m_valid;
    snap_pend  = m_pend;
    snap_over  = m_over;
    if (!Reset) begin
      m_init = 1'b1;
      m_cyc  = 0;
      m_prev = iPushBtn;
      m_pend = '0; m_rep = '0; m_ev = '0; m_evrep = '0;
      m_valid = 1'b0; m_rept = 1'b0; m_over = 1'b0; m_code = '0;
      m_last = 3;
      for (int k = 0; k < 4; k++) begin
        m_active[k] = 1'b0;
        m_ticks[k]  = 0;
      end
    end else begin
      tick  = (m_cyc % TD) == TD - 1;
      m_cyc = m_cyc + 1;
      new_ev  = '0;
      new_rep = '0;
      for (int k = 0; k < 4; k++) begin
        if (!iPushBtn[k] || !iEnable) begin
          m_active[k] = 1'b0;
        end else if (!m_active[k]) begin
          if (!m_prev[k]) begin
            m_active[k] = 1'b1;
            m_ticks[k]  = 0;
            new_ev[k]   = 1'b1;
          end
        end else if (tick) begin
          m_ticks[k] = m_ticks[k] + 1;
          if (m_ticks[k] >= HD && ((m_ticks[k] - HD) % RP) == 0) begin
            new_ev[k]  = 1'b1;
            new_rep[k] = 1'b1;
          end
        end
      end
      load  = !m_valid || iEventReady;
      found = 1'b0;
      g     = 0;
      for (int i = 1; i <= 4; i++) begin
        if (!found && m_pend[(m_last + i) % 4]) begin
          found = 1'b1;
          g     = (m_last + i) % 4;
        end
      end
      if (m_valid && iEventReady) exp_q.push_back({m_code, m_rept});
      for (int k = 0; k < 4; k++)
        if (m_ev[k] && m_pend[k] && !(load && found && g == k)) m_over = 1'b1;
      if (load) begin
        m_valid = found;
        if (found) begin
          m_code    = 2'(g);
          m_rept    = m_rep[g];
          m_pend[g] = 1'b0;
          m_last    = g;
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (m_ev[k]) begin
          m_pend[k] = 1'b1;
          m_rep[k]  = m_evrep[k];
        end
      end
      m_ev    = new_ev;
      m_evrep = new_rep;
      m_prev  = iPushBtn;
    end
  end

  // Monitor: state compare, stability under backpressure, scoreboard pops.
  logic       prev_stall = 1'b0;
  logic [1:0] prev_code;
  logic       prev_rep;

  always @(negedge Clock) begin
    ev_t e;
    #1;
    if (snap_ok) begin
      chk("valid_state", int'(oEventValid), int'(snap_valid));
      chk("pending_state", int'(oPending), int'(snap_pend));
      chk("overrun_state", int'(oOverrun), int'(snap_over));
    end
    if (prev_stall) begin
      chk("stall_valid", int'(oEventValid), 1);
      chk("stall_code", int'(oEventCode), int'(prev_code));
      chk("stall_rep", int'(oEventRepeat), int'(prev_rep));
    end
    if (Reset && oEventValid && iEventReady) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("event_code", int'(oEventCode), int'(e.code));
        chk("event_rep", int'(oEventRepeat), int'(e.rep));
      end
    end
    prev_stall = Reset && oEventValid && !iEventReady;
    prev_code  = oEventCode;
    prev_rep   = oEventRepeat;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge Clock);
    #2;
  endtask

  initial begin
    logic [3:0] flip;
    Reset = 1'b0; iPushBtn = '0; iEnable = 1'b1; iEventReady = 1'b1;
    cyc(3);
    chk("rst_valid", int'(oEventValid), 0);
    chk("rst_pending", int'(oPending), 0);
    chk("rst_overrun", int'(oOverrun), 0);
    Reset = 1'b1;
    cyc(2);

    // single press, released before the first repeat
    iPushBtn = 4'b0001;
    cyc(2);
    chk("lat_early", int'(oEventValid), 0);
    cyc(1);
    chk("lat_valid", int'(oEventValid), 1);
    chk("lat_code", int'(oEventCode), 0);
    chk("lat_rep", int'(oEventRepeat), 0);
    cyc(1);
    chk("lat_one_cycle", int'(oEventValid), 0);
    iPushBtn = 4'b0000;
    cyc(20);

    // hold with auto-repeat
    iPushBtn = 4'b0100;
    cyc(40);
    iPushBtn = 4'b0000;
    cyc(20);
    chk("hold_pending_clear", int'(oPending), 0);

    // simultaneous burst, then again from a different pointer
    iPushBtn = 4'b1111;
    cyc(2);
    iPushBtn = 4'b0000;
    cyc(10);
    iPushBtn = 4'b0010;
    cyc(2);
    iPushBtn = 4'b0000;
    cyc(8);
    iPushBtn = 4'b1111;
    cyc(2);
    iPushBtn = 4'b0000;
    cyc(10);

    // backpressure and overrun
    iEventReady = 1'b0;
    iPushBtn = 4'b1000;
    cyc(40);
    chk("bp_valid", int'(oEventValid), 1);
    chk("bp_code", int'(oEventCode), 3);
    chk("bp_rep", int'(oEventRepeat), 0);
    chk("bp_overrun", int'(oOverrun), 1);
    iEventReady = 1'b1;
    cyc(3);
    iPushBtn = 4'b0000;
    cyc(20);
    chk("overrun_sticky", int'(oOverrun), 1);

    // held through reset, and disabled press
    Reset = 1'b0;
    iPushBtn = 4'b0001;
    cyc(3);
    Reset = 1'b1;
    cyc(10);
    chk("held_thru_rst_valid", int'(oEventValid), 0);
    chk("held_thru_rst_pend", int'(oPending), 0);
    chk("overrun_cleared", int'(oOverrun), 0);
    iPushBtn = 4'b0000;
    cyc(2);
    iEnable = 1'b0;
    iPushBtn = 4'b0010;
    cyc(10);
    chk("disabled_valid", int'(oEventValid), 0);
    chk("disabled_pend", int'(oPending), 0);
    iPushBtn = 4'b0000;
    iEnable = 1'b1;
    cyc(2);

    // reset while an event is presented
    iEventReady = 1'b0;
    iPushBtn = 4'b0001;
    cyc(4);
    chk("mid_hs_valid", int'(oEventValid), 1);
    Reset = 1'b0;
    cyc(1);
    chk("mid_hs_dropped", int'(oEventValid), 0);
    chk("mid_hs_pend", int'(oPending), 0);
    Reset = 1'b1;
    iPushBtn = 4'b0000;
    iEventReady = 1'b1;
    cyc(5);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      flip = '0;
      for (int b = 0; b < 4; b++) flip[b] = ($urandom % 10) == 0;
      iPushBtn    = iPushBtn ^ flip;
      iEventReady = ($urandom % 4) != 0;
      iEnable     = ($urandom % 50) != 0;
      Reset       = ($urandom % 500) != 0;
      cyc(1);
    end

    Reset = 1'b1; iPushBtn = '0; iEnable = 1'b1; iEventReady = 1'b1;
    cyc(40);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
